ahb_decoder_mux: RTL
====================

Name: ahb_decoder_mux

Overview:
- Parametrised AHB-Lite interconnect slice: one manager to NUM_SLAVES subordinates.
- Address-phase decode generates per-slave hselx.
- A registered data-phase select steers the selected slave's hrdata, hreadyout and hresp back to the manager, and the combined hready is broadcast to the manager and all slaves.
- Unmapped accesses go to a built-in default slave that returns the two-cycle AHB ERROR response.

Parameters:
- ADDR_WIDTH, 32: address bus width.
- DATA_WIDTH, 32: read data width.
- NUM_SLAVES, 4: number of subordinate ports, 1..16.
- REGION_BITS, 16: log2 of the region size; region index = haddr[ADDR_WIDTH-1:REGION_BITS].
- TIMEOUT_CYCLES, 256: wait-state limit; used only with the optional feature.

Ports:
- hclk  input  1  bus clock; everything is on the rising edge.
- hreset  input  1  synchronous reset, active-high.
- haddr  input  ADDR_WIDTH  manager address-phase address.
- htrans  input  2  manager transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hselx  output  NUM_SLAVES  one-hot address-phase slave select.
- hreadyout_s  input  NUM_SLAVES  per-slave hreadyout.
- hresp_s  input  NUM_SLAVES  per-slave hresp.
- hrdata_s  input  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- hready  output  1  combined ready to the manager and all slaves.
- hresp  output  1  muxed response to the manager.
- hrdata  output  DATA_WIDTH  muxed read data to the manager.
- decode_err  output  1  one-cycle pulse on the first ERROR cycle of an unmapped access.
- timeout_err  output  1  one-cycle pulse when a timeout fires.

Behaviour:

Address decode (combinational):
- hselx[i] = 1 when region index == i and i < NUM_SLAVES.
- Any other index selects the default slave, and hselx is all-zero.
- hselx follows haddr regardless of htrans.

Data-phase register:
- Updated only on cycles with hready=1.
- Captures the slave index, a default flag and an active flag; active = htrans[1].
- While hready=0 it holds its value; the address phase on the bus is stalled.

FSM states:
- DP_IDLE: no active data phase.
  - Outputs: hready=1, hresp=0, hrdata=0.
- DP_SLAVE: active data phase on mapped slave k.
  - Outputs: hready=hreadyout_s[k], hresp=hresp_s[k], hrdata=hrdata_s[k].
- DP_ERR1: default-slave first cycle.
  - Outputs: hready=0, hresp=1, hrdata=0; decode_err=1.
- DP_ERR2: second cycle.
  - Outputs: hready=1, hresp=1, hrdata=0.

FSM transitions, taken on cycles with hready=1:
- NONSEQ/SEQ to a mapped slave -> DP_SLAVE.
- NONSEQ/SEQ to an unmapped region -> DP_ERR1.
- IDLE/BUSY to any address -> DP_IDLE.
- DP_ERR1 always -> DP_ERR2, since hready=0 in DP_ERR1.
- DP_ERR2 exits on its own hready=1 cycle using the next address phase; back-to-back unmapped NONSEQ gives ERR1, ERR2, ERR1, ERR2.

Other rules:
- A slave error response (hresp_s=1, two cycles) passes through unchanged; the block does not generate its own error for it.
- Reset: state DP_IDLE, data-phase register cleared; hready=1, hresp=0, hrdata=0, decode_err=0, timeout_err=0.
- Reset asserted mid-transfer, including in DP_ERR1 or a slave wait state, abandons the transfer. The next cycle shows the reset outputs.
- Data-phase latency: exactly one cycle after the accepting hready=1 edge, plus slave wait states.
- NUM_SLAVES=1 is supported; the index register may be zero-width internally, while the default flag is still present.

Optional Feature:
- Macro: AHB_DECODER_MUX_TIMEOUT_EN.
- With the macro: a counter of width clog2(TIMEOUT_CYCLES)+1 counts consecutive DP_SLAVE cycles with hreadyout_s[k]=0.
  - On reaching TIMEOUT_CYCLES the block enters DP_ERR1 and then DP_ERR2, giving the manager a two-cycle ERROR.
  - timeout_err pulses on the ERR1 cycle; decode_err stays 0.
  - The slave's late hreadyout/hrdata for that transfer is ignored.
  - The counter clears on any hreadyout_s[k]=1 cycle, on leaving DP_SLAVE, and on reset.
- Without the macro: no counter; wait states are unbounded; timeout_err is tied 0.

Test Plan:

All scenarios use NUM_SLAVES=4 and REGION_BITS=16.
1. NONSEQ read at 0x0002_0010, slave 2 hreadyout=1, hrdata_s slot 2=0xCAFE_0002 -> hselx=4'b0100 in the address cycle; next cycle hrdata=0xCAFE_0002, hready=1, hresp=0.
2. NONSEQ to slave 1, where slave 1 inserts 2 wait states, then NONSEQ to slave 3 -> hready low 2 cycles; hselx=4'b1000 held throughout; slave 3 data phase starts only after slave 1 hready=1.
3. NONSEQ at 0x0009_0000 -> hselx=0; data phase hready=0/hresp=1, then hready=1/hresp=1; decode_err high exactly 1 cycle.
4. IDLE at 0x0009_0000 followed by IDLE -> hready=1, hresp=0, decode_err=0 on every cycle.
5. hreset=1 during DP_ERR1 -> cycle after the reset edge: hready=1, hresp=0, hrdata=0; a following NONSEQ to slave 0 completes normally.
6. With AHB_DECODER_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave 0 holds hreadyout=0 indefinitely -> after 16 wait cycles hready=0/hresp=1, then hready=1/hresp=1; timeout_err pulses once. Without the macro, hready stays 0 for 100 cycles.

Source files
------------

// File: rtl/ahb_decoder_mux.sv
// ahb_decoder_mux: AHB-Lite 1:NUM_SLAVES address decoder and response mux with built-in default (ERROR) slave.
// Optional wait-state timeout enabled by defining AHB_DECODER_MUX_TIMEOUT_EN.
module ahb_decoder_mux #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int REGION_BITS    = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             hclk,
    input  logic                             hreset,
    input  logic [ADDR_WIDTH-1:0]            haddr,
    input  logic [1:0]                       htrans,
    output logic [NUM_SLAVES-1:0]            hselx,
    input  logic [NUM_SLAVES-1:0]            hreadyout_s,
    input  logic [NUM_SLAVES-1:0]            hresp_s,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s,
    output logic                             hready,
    output logic                             hresp,
    output logic [DATA_WIDTH-1:0]            hrdata,
    output logic                             decode_err,
    output logic                             timeout_err
);
    localparam int IW = ADDR_WIDTH - REGION_BITS;
    localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {DP_IDLE, DP_SLAVE, DP_ERR1, DP_ERR2} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            dec_q, dec_d, to_q, to_d;
    logic [IW-1:0]   idx;
    logic            mapped, slv_rdy, fire, unused_ok;

    assign idx       = haddr[ADDR_WIDTH-1:REGION_BITS];
    assign mapped    = 32'(idx) < NUM_SLAVES;
    assign unused_ok = htrans[0];

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
        assign hselx[i] = 32'(idx) == i;
    end

    assign slv_rdy = hreadyout_s[sel_q];

`ifdef AHB_DECODER_MUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] wait_q;
    // Fires on the last tolerated wait cycle so ERR1 follows exactly TIMEOUT_CYCLES waits.
    assign fire = state_q == DP_SLAVE && !slv_rdy && wait_q == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge hclk)
        wait_q <= (hreset || state_q != DP_SLAVE || slv_rdy) ? '0 : wait_q + 1'b1;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign fire = 1'b0;
`endif

    assign hready     = state_q == DP_SLAVE ? slv_rdy : state_q != DP_ERR1;
    assign hresp      = state_q == DP_SLAVE ? hresp_s[sel_q] : (state_q == DP_ERR1 || state_q == DP_ERR2);
    assign hrdata     = state_q == DP_SLAVE ? hrdata_s[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign decode_err = dec_q;
    assign timeout_err = to_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dec_d   = 1'b0;
        to_d    = 1'b0;
        if (fire) begin
            state_d = DP_ERR1;
            to_d    = 1'b1;
        end else if (state_q == DP_ERR1) begin
            state_d = DP_ERR2;
        end else if (hready) begin
            state_d = !htrans[1] ? DP_IDLE : mapped ? DP_SLAVE : DP_ERR1;
            sel_d   = idx[SW-1:0];
            dec_d   = htrans[1] && !mapped;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= DP_IDLE;
            sel_q   <= '0;
            dec_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dec_q   <= dec_d;
            to_q    <= to_d;
        end
    end
endmodule
